pulse_conditioner: RTL
======================

# pulse_conditioner

Conditions a raw, asynchronous, possibly bouncing pulse source (button, opto, comparator) into clean, fixed-width, single-clock-domain pulses. Its `pulse_out` drives the `increment` input of the downstream `pulse_counter`, so every qualified rising edge on the source produces exactly one counter increment. It also reports glitch statistics for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop depth; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles that qualify a level change; legal range ≥ 1.
- `PULSE_WIDTH`, default 4: `pulse_out` high time in clocks; legal range ≥ 1.
- `GLITCH_WIDTH`, default 8: width of the glitch and drop counters.

- `clk`, input, 1: system clock; all logic is rising-edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `raw_in`, input, 1: asynchronous raw source.
- `enable`, input, 1: synchronous pulse-generation enable.
- `pulse_out`, output, 1: registered conditioned pulse; feeds `pulse_counter.increment`.
- `level_out`, output, 1: registered debounced level.
- `glitch_count`, output, GLITCH_WIDTH: count of aborted level changes; saturates.
- `drop_count`, output, GLITCH_WIDTH: count of qualified rises that produced no pulse; saturates.

## Operation
- **Synchronizer.** `raw_in` passes through a chain of `SYNC_STAGES` flops. The last stage is `s_in`. All flops reset to 0.
- **Debounce counter.** Width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - It clears on every state transition.
  - Otherwise it increments while `s_in` differs from `level_out`.
- **FSM states:** LOW, CONFIRM_HIGH, HIGH, CONFIRM_LOW. The reset state is LOW.
- **LOW:**
  - `s_in`=1 → CONFIRM_HIGH, counter = 1.
  - If DEBOUNCE_CYCLES = 1, go directly to HIGH instead.
- **CONFIRM_HIGH:**
  - `s_in`=0 → LOW and `glitch_count` +1.
  - When the counter reaches DEBOUNCE_CYCLES with `s_in` still 1 → HIGH. This is a qualified rise.
- **HIGH:** `s_in`=0 → CONFIRM_LOW. Mirror of LOW.
- **CONFIRM_LOW:**
  - `s_in`=1 → HIGH and `glitch_count` +1.
  - Counter reaches DEBOUNCE_CYCLES → LOW.
- **`level_out`** is 1 exactly in states HIGH and CONFIRM_LOW.
- **Pulse generator.** A down-counter of width `$clog2(PULSE_WIDTH+1)`.
  - A qualified rise with `enable`=1 and the counter at 0 loads PULSE_WIDTH; `pulse_out` = (counter ≠ 0).
  - A qualified rise with `enable`=0, or while the counter ≠ 0, is dropped and `drop_count` +1.
  - An in-flight pulse always completes to full width, even if `enable` falls or the input falls.
- **Counter saturation.** Both counters saturate at 2^GLITCH_WIDTH−1 and never wrap. They clear only on reset.
- **Reset.** Asserting `reset` at any time immediately forces:
  - all outputs to 0: `pulse_out`=0, `level_out`=0, `glitch_count`=0, `drop_count`=0;
  - FSM to LOW;
  - synchronizer and both counters to 0.
  
  After release, a `raw_in` that is already high is treated as a new rise and is debounced normally.

## Timing
- **Rise latency.** `raw_in` rises and stays high, first sampled at edge N:
  - `level_out` and `pulse_out` both go high after edge N + SYNC_STAGES + DEBOUNCE_CYCLES − 1.
  - Total latency is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- **Pulse shape.** `pulse_out` stays high for exactly PULSE_WIDTH cycles, then low until the next qualified rise.
- **Minimum input pulse.** A raw high shorter than DEBOUNCE_CYCLES cycles, as seen at `s_in`, produces no pulse and one glitch.
- **Minimum spacing.** Consecutive qualified rises are at least 2·DEBOUNCE_CYCLES apart. Pulses therefore overlap only when PULSE_WIDTH > 2·DEBOUNCE_CYCLES, and that overlap case is covered by the drop rule.
- **Glitch timing.** `glitch_count` updates on the edge after the aborting `s_in` sample.
- **Simultaneous events.** A qualified rise in the same cycle as the pulse counter reaching 0 is a drop, because the counter is sampled before decrement. Overall, at most one `glitch_count` update and one `drop_count` update occur per cycle.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_WIDTH=3, GLITCH_WIDTH=3.

1. **Reset values.** Hold `reset` with `raw_in`=1 → all outputs are 0. Release with `raw_in`=1 → `pulse_out` rises 6 cycles later and stays high for 3 cycles.
2. **Bounce.** `raw_in` toggles 1,0,1,0 at 1-cycle spacing, then holds 1 → exactly one 3-cycle pulse, and `glitch_count` ≥ 1 (one count per aborted confirm).
3. **Short highs and saturation.** Ten raw highs of 2 cycles each → no `pulse_out`, and `glitch_count` saturates at 7.
4. **Enable low.** `enable`=0 with one clean 10-cycle high → `level_out` follows, `pulse_out` stays 0, `drop_count`=1.
5. **Enable falls mid-pulse.** `enable` falls 1 cycle into a pulse → the pulse still lasts 3 cycles.
6. **Downstream integration.** Connect `pulse_out` to `pulse_counter` with TRIGGER_VALUE=4. Apply four clean raw pulses → `count`=4 and `trigger`=1. Assert `reset` mid-pulse → `pulse_out` drops immediately.

Source files
------------

// File: rtl/pulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_conditioner
//  Brief    : Synchronises, debounces and shapes a raw asynchronous pulse
//             source into fixed-width single-domain pulses, and keeps
//             saturating glitch / drop statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_WIDTH     = 4,
   parameter int GLITCH_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    raw_in,
   input  logic                    enable,
   output logic                    pulse_out,
   output logic                    level_out,
   output logic [GLITCH_WIDTH-1:0] glitch_count,
   output logic [GLITCH_WIDTH-1:0] drop_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW_W = $clog2(PULSE_WIDTH + 1);

   // The confirm state is left on the sample that would bring the count to
   // DEBOUNCE_CYCLES, so the comparison is against DEBOUNCE_CYCLES-1.
   localparam logic [DB_W-1:0]         DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]         DB_ONE   = DB_W'(1);
   localparam logic [PW_W-1:0]         PW_LOAD  = PW_W'(PULSE_WIDTH);
   localparam logic [PW_W-1:0]         PW_ONE   = PW_W'(1);
   localparam logic [GLITCH_WIDTH-1:0] CNT_ONE  = GLITCH_WIDTH'(1);
   localparam logic [GLITCH_WIDTH-1:0] CNT_SAT  = '1;

   typedef enum logic [1:0] {
      ST_LOW          = 2'd0,
      ST_CONFIRM_HIGH = 2'd1,
      ST_HIGH         = 2'd2,
      ST_CONFIRM_LOW  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_in;
   state_t                 state;
   state_t                 state_next;
   logic [DB_W-1:0]        db_cnt;
   logic [DB_W-1:0]        db_cnt_next;
   logic                   glitch_evt;
   logic                   qual_rise;
   logic [PW_W-1:0]        pcnt;
   logic [PW_W-1:0]        pcnt_next;
   logic                   drop_evt;

   // Multi-flop synchroniser; raw_in enters at bit 0, s_in is the last stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
   end

   assign s_in = sync_q[SYNC_STAGES-1];

   // Debounce FSM state, debounce counter and registered level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_LOW;
         db_cnt    <= '0;
         level_out <= 1'b0;
      end else begin
         state     <= state_next;
         db_cnt    <= db_cnt_next;
         level_out <= (state_next == ST_HIGH) || (state_next == ST_CONFIRM_LOW);
      end
   end

   // Next-state logic; entering a confirm state counts the first differing sample.
   always_comb begin
      state_next  = state;
      db_cnt_next = db_cnt;
      glitch_evt  = 1'b0;
      qual_rise   = 1'b0;
      if (s_in != level_out) db_cnt_next = db_cnt + DB_ONE;
      case (state)
         ST_LOW: begin
            if (s_in) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_next  = ST_HIGH;
                  db_cnt_next = '0;
                  qual_rise   = 1'b1;
               end else begin
                  state_next  = ST_CONFIRM_HIGH;
                  db_cnt_next = DB_ONE;
               end
            end
         end
         ST_CONFIRM_HIGH: begin
            if (!s_in) begin
               state_next  = ST_LOW;
               db_cnt_next = '0;
               glitch_evt  = 1'b1;
            end else if (db_cnt == DB_LAST) begin
               state_next  = ST_HIGH;
               db_cnt_next = '0;
               qual_rise   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (!s_in) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_next  = ST_LOW;
                  db_cnt_next = '0;
               end else begin
                  state_next  = ST_CONFIRM_LOW;
                  db_cnt_next = DB_ONE;
               end
            end
         end
         ST_CONFIRM_LOW: begin
            if (s_in) begin
               state_next  = ST_HIGH;
               db_cnt_next = '0;
               glitch_evt  = 1'b1;
            end else if (db_cnt == DB_LAST) begin
               state_next  = ST_LOW;
               db_cnt_next = '0;
            end
         end
         default: begin
            state_next  = ST_LOW;
            db_cnt_next = '0;
         end
      endcase
   end

   // Pulse down-counter: a rise only loads when idle and enabled, otherwise it
   // is dropped; the counter is sampled before its own decrement.
   always_comb begin
      pcnt_next = pcnt;
      drop_evt  = 1'b0;
      if (qual_rise && enable && (pcnt == '0)) begin
         pcnt_next = PW_LOAD;
      end else begin
         if (qual_rise)    drop_evt  = 1'b1;
         if (pcnt != '0)   pcnt_next = pcnt - PW_ONE;
      end
   end

   // Pulse counter and registered pulse output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt      <= '0;
         pulse_out <= 1'b0;
      end else begin
         pcnt      <= pcnt_next;
         pulse_out <= (pcnt_next != '0);
      end
   end

   // Saturating count of aborted level changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    glitch_count <= '0;
      else if (glitch_evt && glitch_count != CNT_SAT) glitch_count <= glitch_count + CNT_ONE;
   end

   // Saturating count of qualified rises that produced no pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                drop_count <= '0;
      else if (drop_evt && drop_count != CNT_SAT) drop_count <= drop_count + CNT_ONE;
   end

endmodule
`default_nettype wire
